// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, flag bit positions
// and the control FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_SLA = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam int FLG_Z = 0;
  localparam int FLG_V = 1;
  localparam int FLG_N = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the register-read stage and the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                    start;
  logic [2:0]              opcode;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] result;
  logic [2:0]              flags;

  modport master (
    output start, opcode, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/seq_alu_mul_core.sv
// Iterative sign-magnitude multiplier: one shift-add per step, product
// presented already sign-corrected on the final step.
module seq_mul_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic [2*WIDTH-1:0]      product,
  output logic                    last
);

  logic [2*WIDTH:0] mcand_q;
  logic [WIDTH:0]   mplier_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_nxt;
  logic [2*WIDTH:0] signed_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;

  // One extra bit keeps |-2^(W-1)| representable.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? -ext : ext;
  endfunction

  always_comb begin
    acc_nxt    = acc_q + (mplier_q[0] ? mcand_q : '0);
    signed_nxt = neg_q ? -acc_nxt : acc_nxt;
  end

  assign product = signed_nxt[2*WIDTH-1:0];
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag(a)};
      mplier_q <= mag(b);
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered 8-op ALU: single-cycle ops finish one clock after accept,
// MUL is delegated to the iterative core behind the busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  state_t             state_q, state_d;
  logic               accept;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         flags_q;

  function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic v);
    logic [2:0] f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_V] = v;
    f[FLG_N] = r[WIDTH-1];
    return f;
  endfunction

  seq_mul_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.a),
    .b       (bus.b),
    .product (mul_prod),
    .last    (mul_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.opcode == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL_ITER;
          end else begin
            state_d  = DONE;
          end
        end
      end
      MUL_ITER: begin
        mul_step = 1'b1;
        if (mul_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated straight from the accepted operands.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (bus.opcode)
      OP_SLA: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_v   = bus.a[WIDTH-1] ^ bus.a[WIDTH-2];
      end
      OP_SRA: alu_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
      OP_ADD: begin
        alu_res = bus.a + bus.b;
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOT:  alu_res = ~bus.a;
      default: alu_res = '0;
    endcase
  end

  // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
  assign mul_v = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || (~|mul_prod[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= 3'b000;
    end else if (accept && (bus.opcode != OP_MUL)) begin
      result_q <= alu_res;
      flags_q  <= mk_flags(alu_res, alu_v);
    end else if (mul_step && mul_last) begin
      result_q <= mul_prod[WIDTH-1:0];
      flags_q  <= mk_flags(mul_prod[WIDTH-1:0], mul_v);
    end
  end

  assign bus.busy   = (state_q == MUL_ITER);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 8-op combinational ALU; same opcode map and flag layout, generic data width.
- Single-cycle ops complete one clock after start; MUL runs as an iterative shift-add over WIDTH cycles behind a start/busy/done handshake.
- Sits between the register-read stage and write-back of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits, must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; the clock is clk and the reset is rst_n.
- start  in  1  request; accepted only when busy=0.
- opcode  in  3  0 SLA, 1 SRA, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 NOT.
- a  in  WIDTH  signed operand A, sampled on accept.
- b  in  WIDTH  signed operand B, sampled on accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  low WIDTH bits of the result, held until the next done.
- flags  out  3  [0] zero, [1] overflow, [2] negative; held with result.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, flags=3'b000, counter=0, accumulator=0. Reset mid-MUL abandons the operation, and no done is issued.
- Accept: start=1 while state IDLE. Opcode, a and b are latched. If start=1 while busy=1, it is ignored, with no queueing.
- States:
  - IDLE: on accept of a non-MUL op, go to DONE. On accept of MUL, go to MUL_ITER.
  - MUL_ITER: runs for WIDTH cycles, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Latency (accept edge to done high): non-MUL ops 1 cycle; MUL WIDTH+1 cycles. busy=1 in MUL_ITER only; busy=0 in IDLE and DONE.
- Back-to-back: a start in the cycle after done is accepted, giving a throughput of 1 op per 2 cycles for single-cycle ops.
- SLA: result={a[W-2:0],0}; overflow=a[W-1]^a[W-2].
- SRA: result={a[W-1],a[W-1:1]}; overflow=0.
- ADD and SUB: WIDTH-bit two's-complement arithmetic, wrapping.
  - Overflow = operands' signs (b inverted for SUB) agree and the result sign differs.
- MUL: sign-magnitude method.
  - Magnitudes are held in WIDTH+1 bits so that -2^(W-1) is exact.
  - Unsigned shift-add runs one bit per cycle into a 2*WIDTH+1 accumulator. The product is negated at DONE entry if a[W-1]^b[W-1].
  - result = low WIDTH bits of the product.
  - Overflow=1 unless product bits [2W-1:W-1] are all equal.
  - Operand 0 still takes full latency.
- AND: a&b. OR: a|b. NOT: ~a. Overflow=0 for all logic ops.
- Flags for every op:
  - zero = (result==0).
  - negative = result[W-1], including for MUL, so a product of 0 gives negative=0.
- Flags are never X or Z.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_SLA..OP_NOT;
  - flag indices FLG_Z=0, FLG_V=1, FLG_N=2;
  - state enum {IDLE, MUL_ITER, DONE}.
- Sub-module seq_mul_core (WIDTH) holds the magnitude prep, iteration counter, accumulator and final negate.
  - Interface: load, step, product[2W-1:0], last.
  - seq_alu owns the FSM, the single-cycle ops and the flags.

Test Plan (WIDTH=32):
- Reset mid-MUL: start MUL a=7 b=9, drop rst_n at cycle 10 -> outputs immediately 0, no done; after release, ADD 1+2 -> done after 1 cycle, result=3, flags=000.
- ADD 0x7FFFFFFF+1 -> result 0x80000000, flags=110. SUB 5-5 -> result 0, flags=001.
- MUL -3*7 -> done exactly 33 cycles after accept, busy high 32 cycles, result 0xFFFFFFEB, flags=100. MUL 0x80000000*(-1) -> result 0x80000000, flags=110.
- MUL 0x00010000*0x00010000 -> result 0, flags=011. Start pulsed while busy -> ignored, single done.
- SLA 0x40000000 -> result 0x80000000, flags=110. SRA 0x80000001 -> result 0xC0000000, flags=100. OR 0xF0 | 0x0F -> result 0xFF, flags=000.
- NOT 0xFFFFFFFF -> result 0, flags=001.
- Back-to-back AND ops, each start issued in the cycle after done -> every op completes, with one done per op.
